spi_wb_bridge: RTL
==================

# spi_wb_bridge

Converts the byte stream from the SPI Mode 0 shift core into Wishbone classic single-beat bus cycles in the system clock domain. It sits directly downstream of the SPI core. It consumes the core's received byte and byte-complete strobe, and it feeds the core's transmit byte. The MCU uses it to read and write any location in the 128 KB PET address space, with optional address auto-increment.

## Interface
Parameters:
- ADDR_WIDTH, 17: Wishbone address width. Bit 16 comes from the command byte.
- DATA_WIDTH, 8: byte width. Must match the SPI core.

Ports:
- wb_clk_i  in  1  system clock; all logic is on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- spi_cs_ni  in  1  raw SPI chip select (active low); asynchronous to wb_clk_i.
- spi_cycle_i  in  1  byte-complete strobe from the SPI core (SCK domain).
- spi_data_i  in  DATA_WIDTH  received byte from the SPI core (SCK domain).
- spi_data_o  out  DATA_WIDTH  next byte for the SPI core to transmit.
- wb_adr_o  out  ADDR_WIDTH  bus address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_we_o  out  1  write enable.
- wb_cyc_o, wb_stb_o  out  1  cycle and strobe, always asserted together.
- wb_ack_i  in  1  cycle termination.

## Operation
- **Synchronization:**
  - spi_cs_ni and spi_cycle_i each pass through a 2-flop synchronizer.
  - A byte event is the rising edge of the synchronized spi_cycle_i.
  - spi_data_i is registered on the same wb_clk edge that detects the byte event.
- **Command byte** (first byte after CS falls):
  - bit7 = WE.
  - bit6 = INC.
  - bits5:1 are reserved and ignored.
  - bit0 = A16.
- **Frame layout:** CMD, ADDR_HI (A15:8), ADDR_LO (A7:0), then payload bytes.
- **FSM states:** CMD → ADDR_HI → ADDR_LO → PAYLOAD ↔ BUS → PAYLOAD; plus DRAIN.
- **Write:**
  - Each payload byte event latches wb_dat_o, then enters BUS with wb_we_o=1.
  - On ack, if INC, addr ← addr+1.
- **Read:**
  - The ADDR_LO byte event enters BUS with wb_we_o=0.
  - Each later payload byte event also enters BUS; if INC, addr increments before that read.
  - On ack, spi_data_o ← wb_dat_i.
  - The host sends one dummy turnaround byte after ADDR_LO. The first read data appears in the following byte slot.
- **BUS state:**
  - wb_cyc_o and wb_stb_o are held high until wb_ack_i.
  - Deasserted on the clock after ack; return to PAYLOAD.
- **Address arithmetic:** increments modulo 2^ADDR_WIDTH, so 0x1FFFF+1 = 0x00000.
- **CS deassert** (synchronized high):
  - From CMD, ADDR_HI, ADDR_LO or PAYLOAD: go to CMD immediately.
  - From BUS: go to DRAIN. The bus cycle completes on ack and is never truncated. Then go to CMD.
  - Byte events seen while CS is high are ignored.
- **Byte event during BUS** (host overran the bus): the byte is dropped and a sticky overrun flag is set internally. The flag clears on the next CS falling edge.
- **Reset values:**
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0.
  - wb_adr_o=0, wb_dat_o=0.
  - spi_data_o=0.
  - FSM=CMD, synchronizers cleared.
- **Reset mid-cycle:** all outputs return to reset values asynchronously. The upstream bus slave must tolerate an abandoned cycle.

## Timing
- Byte event latency: 3 wb_clk edges from the spi_cycle_i rise to the FSM action (2 sync + 1 edge-detect).
- Write: wb_cyc_o rises 1 clock after the byte event is registered, i.e. about 4 clocks after the spi_cycle_i rise.
- Read data: spi_data_o updates on the clock after wb_ack_i.
- **System constraints:**
  - SCK half-period ≥ 3 wb_clk periods, so spi_data_i is stable when sampled.
  - Byte period ≥ 8 + (Wishbone wait states) wb_clk periods, so spi_data_o is stable before the SPI core loads it.
- CS-to-CMD latency: 2 clocks after CS rises (3 if DRAIN waits on ack).

## Test plan
- **Single write:** CS low, bytes 0x80,0x80,0x00,0x5A. Required: one cycle with adr=0x08000, dat_o=0x5A, we=1; cyc high until ack; no further cycles.
- **Auto-increment write with wrap:** bytes 0xC1,0xFF,0xFF,0x11,0x22. Required: writes 0x11@0x1FFFF, then 0x22@0x00000.
- **Read with turnaround:** memory[0x0E800]=0xA5, [0x0E801]=0x3C. Bytes 0x40,0xE8,0x00,dummy,dummy,dummy. Required: reads at 0x0E800 then 0x0E801; MISO bytes 4 and 5 = 0xA5, 0x3C.
- **CS abort mid-bus:** stall ack 20 clocks during a write; raise CS at clock 5. Required: cyc held until ack, then FSM=CMD. The next frame's first byte is decoded as a command.
- **Async reset mid-frame:** assert wb_rst_ni low during ADDR_HI with cyc=0. Required: all outputs 0 immediately. After release, a fresh frame 0x80,0x00,0x10,0x77 writes 0x77@0x00010.
- **Overrun:** ack stalled longer than one byte period. Required: the second data byte is dropped, exactly one bus cycle is issued, and the overrun flag is set then cleared on the next CS fall.

Source files
------------

// File: rtl/spi_wb_bridge.sv
// SPI byte stream to Wishbone classic single-beat bridge: CMD, ADDR_HI, ADDR_LO,
// then payload bytes, each turned into one bus cycle in the wb_clk_i domain.
`timescale 1ns/1ps
module spi_wb_bridge #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  spi_cs_ni,
  input  logic                  spi_cycle_i,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  output logic [DATA_WIDTH-1:0] spi_data_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i
);

  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_PAYLOAD, ST_BUS, ST_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic cs_p0, cs_p1, cs_p2;
  logic cyc_p0, cyc_p1, cyc_p2;
  logic evt_p3;
  logic [DATA_WIDTH-1:0] data_p3;

  logic we_r, inc_r, overrun;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r, miso_r;

  logic cs_hi, cs_fall, byte_evt;
  logic ld_cmd, ld_hi, ld_lo, ld_dat, ld_miso, adr_inc, set_ovr, bus_act;

  // p0/p1: two-flop synchronizers; p2: edge-detect delay; p3: registered byte event
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cs_p0  <= 1'b0;
      cs_p1  <= 1'b0;
      cs_p2  <= 1'b0;
      cyc_p0 <= 1'b0;
      cyc_p1 <= 1'b0;
      cyc_p2 <= 1'b0;
      evt_p3 <= 1'b0;
    end else begin
      cs_p0  <= spi_cs_ni;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
      cyc_p0 <= spi_cycle_i;
      cyc_p1 <= cyc_p0;
      cyc_p2 <= cyc_p1;
      evt_p3 <= cyc_p1 & ~cyc_p2;
    end
  end

  // SCK-domain byte is stable here because the SCK half-period spans several clocks
  always_ff @(posedge wb_clk_i) begin
    if (cyc_p1 & ~cyc_p2) data_p3 <= spi_data_i;
  end

  assign cs_hi    = cs_p1;
  assign cs_fall  = cs_p2 & ~cs_p1;
  assign byte_evt = evt_p3 & ~cs_hi;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_CMD;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_cmd    = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    ld_dat    = 1'b0;
    ld_miso   = 1'b0;
    adr_inc   = 1'b0;
    set_ovr   = 1'b0;
    bus_act   = 1'b0;
    case (state)
      ST_CMD: begin
        if (byte_evt) begin
          ld_cmd    = 1'b1;
          state_nxt = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (cs_hi) state_nxt = ST_CMD;
        else if (byte_evt) begin
          ld_hi     = 1'b1;
          state_nxt = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (cs_hi) state_nxt = ST_CMD;
        else if (byte_evt) begin
          ld_lo     = 1'b1;
          state_nxt = we_r ? ST_PAYLOAD : ST_BUS;
        end
      end
      ST_PAYLOAD: begin
        if (cs_hi) state_nxt = ST_CMD;
        else if (byte_evt) begin
          ld_dat    = we_r;
          adr_inc   = ~we_r & inc_r;
          state_nxt = ST_BUS;
        end
      end
      ST_BUS, ST_DRAIN: begin
        // A cycle in flight is always completed, even after CS goes away
        bus_act = 1'b1;
        set_ovr = (state == ST_BUS) & byte_evt;
        if (wb_ack_i) begin
          adr_inc   = we_r & inc_r;
          ld_miso   = ~we_r;
          state_nxt = (cs_hi || state == ST_DRAIN) ? ST_CMD : ST_PAYLOAD;
        end else if (cs_hi) begin
          state_nxt = ST_DRAIN;
        end
      end
      default: state_nxt = ST_CMD;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_r    <= 1'b0;
      inc_r   <= 1'b0;
      overrun <= 1'b0;
      adr_r   <= '0;
      dat_r   <= '0;
      miso_r  <= '0;
    end else begin
      overrun <= cs_fall ? 1'b0 : (overrun | set_ovr);
      if (ld_cmd) begin
        we_r  <= data_p3[7];
        inc_r <= data_p3[6];
        adr_r <= ADDR_WIDTH'({data_p3[0], 16'h0000});
      end
      if (ld_hi)   adr_r[15:8] <= data_p3;
      if (ld_lo)   adr_r[7:0]  <= data_p3;
      if (adr_inc) adr_r       <= adr_r + ADDR_WIDTH'(1);
      if (ld_dat)  dat_r       <= data_p3;
      if (ld_miso) miso_r      <= wb_dat_i;
    end
  end

  assign wb_cyc_o   = bus_act;
  assign wb_stb_o   = bus_act;
  assign wb_we_o    = bus_act & we_r;
  assign wb_adr_o   = adr_r;
  assign wb_dat_o   = dat_r;
  assign spi_data_o = miso_r;

endmodule
